tank_unit: RTL and testbench

Per-player tank controller for the tile-grid game, the parametrised successor to the single-bullet tank logic. It holds one tank and up to NUM_BUL bullets on a MAP_W x MAP_H grid. On each `tick` it runs a fixed-length sequence through a shared synchronous map RAM read port: tank move check, then a per-bullet advance/collide step, then fire/spawn. Brick destruction goes out as explicit map write strobes, so no whole-map copies are needed.

---
 rtl/tank_pkg.sv | 42 ++++
 rtl/tank_unit_if.sv | 26 ++
 rtl/tank_keymap.sv | 38 +++
 rtl/tank_unit.sv | 223 ++++++++++++++++++++++
 tb/tb_tank_unit.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tank_pkg.sv
// Shared types for the tank controller: tile codes, directions, HID keycodes
// and the step sequencer states.
package tank_pkg;

  typedef enum logic [1:0] {
    TILE_EMPTY = 2'd0,
    TILE_WALL  = 2'd1,
    TILE_BRICK = 2'd2,
    TILE_RSVD  = 2'd3
  } tile_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  // Player 0: WASD + Q
  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_Q     = 8'h14;
  // Player 1: arrows + Enter
  localparam logic [7:0] KEY_UP    = 8'h52;
  localparam logic [7:0] KEY_LEFT  = 8'h50;
  localparam logic [7:0] KEY_DOWN  = 8'h51;
  localparam logic [7:0] KEY_RIGHT = 8'h4F;
  localparam logic [7:0] KEY_ENTER = 8'h28;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_T_RD  = 3'd1,
    ST_T_CHK = 3'd2,
    ST_B_RD  = 3'd3,
    ST_B_CHK = 3'd4,
    ST_FIRE  = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

endpackage

// File: rtl/tank_unit_if.sv
// Map RAM port bundle: one synchronous read port and one write strobe port.
interface tank_unit_if #(
  parameter int AW = 9
);
  logic [AW-1:0] map_raddr;
  logic [1:0]    map_rdata;
  logic          map_we;
  logic [AW-1:0] map_waddr;
  logic [1:0]    map_wdata;

  modport master (
    output map_raddr,
    input  map_rdata,
    output map_we,
    output map_waddr,
    output map_wdata
  );

  modport slave (
    input  map_raddr,
    output map_rdata,
    input  map_we,
    input  map_waddr,
    input  map_wdata
  );
endinterface

// File: rtl/tank_keymap.sv
// Decodes a HID keycode into a move request and a fire request for one player.
module tank_keymap
  import tank_pkg::*;
#(
  parameter int PLAYER = 0
) (
  input  logic [7:0] keycode,
  output logic       move_valid,
  output dir_t       move_dir,
  output logic       fire
);

  always_comb begin
    move_valid = 1'b0;
    move_dir   = DIR_UP;
    fire       = 1'b0;
    if (PLAYER == 0) begin
      case (keycode)
        KEY_W:   begin move_valid = 1'b1; move_dir = DIR_UP;    end
        KEY_A:   begin move_valid = 1'b1; move_dir = DIR_LEFT;  end
        KEY_S:   begin move_valid = 1'b1; move_dir = DIR_DOWN;  end
        KEY_D:   begin move_valid = 1'b1; move_dir = DIR_RIGHT; end
        KEY_Q:   fire = 1'b1;
        default: ;
      endcase
    end else begin
      case (keycode)
        KEY_UP:    begin move_valid = 1'b1; move_dir = DIR_UP;    end
        KEY_LEFT:  begin move_valid = 1'b1; move_dir = DIR_LEFT;  end
        KEY_DOWN:  begin move_valid = 1'b1; move_dir = DIR_DOWN;  end
        KEY_RIGHT: begin move_valid = 1'b1; move_dir = DIR_RIGHT; end
        KEY_ENTER: fire = 1'b1;
        default:   ;
      endcase
    end
  end

endmodule

// File: rtl/tank_unit.sv
// One player's tank plus NUM_BUL bullets; each tick runs a fixed-length step
// through the shared map read port and emits brick removals as write strobes.
module tank_unit
  import tank_pkg::*;
#(
  parameter int MAP_W    = 20,
  parameter int MAP_H    = 15,
  parameter int NUM_BUL  = 2,
  parameter int COOLDOWN = 8,
  parameter int PLAYER   = 0,
  parameter int START_X  = 1,
  parameter int START_Y  = 13
) (
  input  logic                                    frame_clk,
  input  logic                                    Reset,
  input  logic                                    tick,
  input  logic [7:0]                              keycode,
  tank_unit_if.master                             map,
  output logic [$clog2(MAP_W)-1:0]                tank_x,
  output logic [$clog2(MAP_H)-1:0]                tank_y,
  output logic [1:0]                              tank_dir,
  output logic [NUM_BUL-1:0][$clog2(MAP_W)-1:0]   bul_x,
  output logic [NUM_BUL-1:0][$clog2(MAP_H)-1:0]   bul_y,
  output logic [NUM_BUL-1:0]                      bul_live,
  output logic                                    busy,
  output logic                                    done
);

  localparam int AW = $clog2(MAP_W * MAP_H);
  localparam int XW = $clog2(MAP_W);
  localparam int YW = $clog2(MAP_H);
  localparam int IW = (NUM_BUL > 1) ? $clog2(NUM_BUL) : 1;
  localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  function automatic int dir_dx(input dir_t d);
    case (d)
      DIR_LEFT:  return -1;
      DIR_RIGHT: return 1;
      default:   return 0;
    endcase
  endfunction

  function automatic int dir_dy(input dir_t d);
    case (d)
      DIR_UP:   return -1;
      DIR_DOWN: return 1;
      default:  return 0;
    endcase
  endfunction

  function automatic logic in_grid(input int x, input int y);
    return (x >= 0) && (x < MAP_W) && (y >= 0) && (y < MAP_H);
  endfunction

  function automatic logic [AW-1:0] tile_addr(input int x, input int y);
    return AW'(y * MAP_W + x);
  endfunction

  state_t          state, state_nx;
  logic [IW-1:0]   slot;
  logic            last_slot;
  logic [7:0]      key_q;
  logic            move_valid;
  dir_t            move_dir;
  logic            fire;
  logic [CW-1:0]   cd_q;
  logic            cd_zero_q;
  dir_t            tank_dir_q;
  dir_t            bul_dir [NUM_BUL];

  logic            t_ok_q;
  logic [XW-1:0]   t_x_q;
  logic [YW-1:0]   t_y_q;
  logic            b_ok_q;
  logic [XW-1:0]   b_x_q;
  logic [YW-1:0]   b_y_q;
  logic [AW-1:0]   b_addr_q;

  int              ttx, tty, btx, bty;
  logic            t_in, b_in;
  logic            any_free;
  logic [IW-1:0]   free_idx;
  logic            brick_hit;

  tank_keymap #(.PLAYER(PLAYER)) u_keymap (
    .keycode    (key_q),
    .move_valid (move_valid),
    .move_dir   (move_dir),
    .fire       (fire)
  );

  // Candidate targets for the tank and for the bullet slot under service
  always_comb begin
    ttx      = int'(tank_x) + dir_dx(move_dir);
    tty      = int'(tank_y) + dir_dy(move_dir);
    t_in     = in_grid(ttx, tty);
    btx      = int'(bul_x[slot]) + dir_dx(bul_dir[slot]);
    bty      = int'(bul_y[slot]) + dir_dy(bul_dir[slot]);
    b_in     = in_grid(btx, bty);
    any_free = 1'b0;
    free_idx = '0;
    for (int i = NUM_BUL - 1; i >= 0; i--) begin
      if (!bul_live[i]) begin
        any_free = 1'b1;
        free_idx = IW'(i);
      end
    end
  end

  assign last_slot = (slot == IW'(NUM_BUL - 1));

  // Reads are only issued for live, in-grid targets; otherwise the port idles at 0
  always_comb begin
    map.map_raddr = '0;
    if (state == ST_T_RD && move_valid && t_in)
      map.map_raddr = tile_addr(ttx, tty);
    else if (state == ST_B_RD && bul_live[slot] && b_in)
      map.map_raddr = tile_addr(btx, bty);
    brick_hit     = (state == ST_B_CHK) && b_ok_q && (map.map_rdata == TILE_BRICK);
    map.map_we    = brick_hit;
    map.map_waddr = brick_hit ? b_addr_q : '0;
  end

  assign map.map_wdata = TILE_EMPTY;

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (tick) state_nx = ST_T_RD;
      ST_T_RD:  state_nx = ST_T_CHK;
      ST_T_CHK: state_nx = ST_B_RD;
      ST_B_RD:  state_nx = ST_B_CHK;
      ST_B_CHK: state_nx = last_slot ? ST_FIRE : ST_B_RD;
      ST_FIRE:  state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);
  assign tank_dir = tank_dir_q;

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      slot       <= '0;
      key_q      <= '0;
      cd_q       <= '0;
      cd_zero_q  <= 1'b0;
      tank_x     <= XW'(START_X);
      tank_y     <= YW'(START_Y);
      tank_dir_q <= DIR_UP;
      bul_x      <= '0;
      bul_y      <= '0;
      bul_live   <= '0;
      for (int i = 0; i < NUM_BUL; i++) bul_dir[i] <= DIR_UP;
      t_ok_q     <= 1'b0;
      t_x_q      <= '0;
      t_y_q      <= '0;
      b_ok_q     <= 1'b0;
      b_x_q      <= '0;
      b_y_q      <= '0;
      b_addr_q   <= '0;
    end else begin
      case (state)
        // A spawn needs a tick that starts with the counter empty, so
        // successive spawns land COOLDOWN+1 ticks apart.
        ST_IDLE: if (tick) begin
          key_q     <= keycode;
          cd_zero_q <= (cd_q == '0);
          if (cd_q != '0) cd_q <= cd_q - 1'b1;
        end
        ST_T_RD: begin
          if (move_valid) tank_dir_q <= move_dir;
          t_ok_q <= move_valid && t_in;
          t_x_q  <= XW'(ttx);
          t_y_q  <= YW'(tty);
          slot   <= '0;
        end
        ST_T_CHK: begin
          if (t_ok_q && map.map_rdata == TILE_EMPTY) begin
            tank_x <= t_x_q;
            tank_y <= t_y_q;
          end
        end
        ST_B_RD: begin
          b_ok_q   <= bul_live[slot] && b_in;
          b_x_q    <= XW'(btx);
          b_y_q    <= YW'(bty);
          b_addr_q <= tile_addr(btx, bty);
        end
        // Out-of-grid, wall, reserved and brick all kill the bullet
        ST_B_CHK: begin
          if (bul_live[slot]) begin
            if (b_ok_q && map.map_rdata == TILE_EMPTY) begin
              bul_x[slot] <= b_x_q;
              bul_y[slot] <= b_y_q;
            end else begin
              bul_live[slot] <= 1'b0;
            end
          end
          if (!last_slot) slot <= slot + 1'b1;
        end
        ST_FIRE: begin
          if (fire && cd_zero_q && any_free) begin
            bul_live[free_idx] <= 1'b1;
            bul_x[free_idx]    <= tank_x;
            bul_y[free_idx]    <= tank_y;
            bul_dir[free_idx]  <= tank_dir_q;
            cd_q               <= CW'(COOLDOWN);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tank_unit.sv
// Directed bench for tank_unit: table of movement ticks plus hand-written
// sequences for bullets, bricks, cooldown, busy ticks and mid-step reset.
module tb_tank_unit;
  import tank_pkg::*;

  localparam int MAP_W = 20;
  localparam int MAP_H = 15;
  localparam int AW    = 9;

  logic            frame_clk = 1'b0;
  logic            Reset     = 1'b1;
  logic            tick      = 1'b0;
  logic [7:0]      keycode   = 8'h00;
  logic [4:0]      tank_x;
  logic [3:0]      tank_y;
  logic [1:0]      tank_dir;
  logic [1:0][4:0] bul_x;
  logic [1:0][3:0] bul_y;
  logic [1:0]      bul_live;
  logic            busy;
  logic            done;

  tank_unit_if #(.AW(AW)) mif ();

  tank_unit #(
    .MAP_W(MAP_W), .MAP_H(MAP_H), .NUM_BUL(2), .COOLDOWN(8),
    .PLAYER(0), .START_X(1), .START_Y(13)
  ) dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .tick      (tick),
    .keycode   (keycode),
    .map       (mif),
    .tank_x    (tank_x),
    .tank_y    (tank_y),
    .tank_dir  (tank_dir),
    .bul_x     (bul_x),
    .bul_y     (bul_y),
    .bul_live  (bul_live),
    .busy      (busy),
    .done      (done)
  );

  always #5 frame_clk = ~frame_clk;

  // Map RAM model: synchronous read, write visible to the next read
  logic [1:0]    mem [MAP_W*MAP_H];
  logic          clr_en    = 1'b0;
  logic          poke_en   = 1'b0;
  logic [AW-1:0] poke_addr = '0;
  logic [1:0]    poke_val  = '0;
  int            we_cnt    = 0;
  int            done_cnt  = 0;
  int            last_waddr = 0;
  int            last_wdata = 0;

  always @(posedge frame_clk) begin
    if (clr_en) begin
      for (int i = 0; i < MAP_W*MAP_H; i++) mem[i] <= 2'd0;
    end else if (poke_en) begin
      mem[poke_addr] <= poke_val;
    end else if (mif.map_we) begin
      mem[mif.map_waddr] <= mif.map_wdata;
    end
    mif.map_rdata <= mem[mif.map_raddr];
  end

  always @(posedge frame_clk) begin
    if (mif.map_we) begin
      we_cnt     <= we_cnt + 1;
      last_waddr <= int'(mif.map_waddr);
      last_wdata <= int'(mif.map_wdata);
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  int nvec  = 0;
  int nfail = 0;
  int rd_log [0:16];

  task automatic check(input string nm, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: actual %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge frame_clk);
      #1;
    end
  endtask

  task automatic poke(input int a, input logic [1:0] v);
    poke_addr = AW'(a);
    poke_val  = v;
    poke_en   = 1'b1;
    step(1);
    poke_en   = 1'b0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick  = 1'b0;
    step(1);
    clr_en = 1'b1;
    step(1);
    clr_en = 1'b0;
    Reset  = 1'b0;
    step(1);
  endtask

  // One accepted tick; lat is the cycle (T_RD = 1) where done is seen, 0 on timeout
  task automatic do_tick(input logic [7:0] key, output int lat);
    keycode = key;
    tick    = 1'b1;
    step(1);
    tick    = 1'b0;
    keycode = 8'h00;
    lat     = 0;
    for (int c = 1; c <= 16; c++) begin
      rd_log[c] = int'(mif.map_raddr);
      if (done) begin
        lat = c;
        break;
      end
      step(1);
    end
    step(1);
  endtask

  typedef struct {
    logic [7:0] key;
    int         ex;
    int         ey;
    int         edir;
  } vec_t;

  vec_t tv [15];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, w0, d0, ex0;

    tv[0]  = '{8'h1A, 1, 12, 0};
    tv[1]  = '{8'h1A, 1, 12, 0};
    tv[2]  = '{8'h04, 0, 12, 1};
    tv[3]  = '{8'h1A, 0, 11, 0};
    for (int i = 0; i < 6; i++) tv[4+i] = '{8'h1A, 0, 10 - i, 0};
    tv[10] = '{8'h04, 0, 5, 1};
    tv[11] = '{8'h00, 0, 5, 1};
    tv[12] = '{8'h52, 0, 5, 1};
    tv[13] = '{8'h16, 0, 6, 2};
    tv[14] = '{8'h07, 1, 6, 3};

    // Reset state
    do_reset();
    check("rst_tank_x", int'(tank_x), 1);
    check("rst_tank_y", int'(tank_y), 13);
    check("rst_tank_dir", int'(tank_dir), 0);
    check("rst_bul_live", int'(bul_live), 0);
    check("rst_bul_x", int'(bul_x), 0);
    check("rst_bul_y", int'(bul_y), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_we", int'(mif.map_we), 0);
    check("rst_raddr", int'(mif.map_raddr), 0);
    check("rst_waddr", int'(mif.map_waddr), 0);
    check("rst_wdata", int'(mif.map_wdata), 0);
    step(5);
    check("idle_busy", int'(busy), 0);
    check("idle_done_cnt", done_cnt, 0);
    check("idle_we_cnt", we_cnt, 0);

    // Movement table; wall at (1,11)
    poke(11*MAP_W + 1, 2'd1);
    for (int i = 0; i < 15; i++) begin
      do_tick(tv[i].key, lat);
      check($sformatf("v%0d_lat", i), lat, 8);
      check($sformatf("v%0d_tank_x", i), int'(tank_x), tv[i].ex);
      check($sformatf("v%0d_tank_y", i), int'(tank_y), tv[i].ey);
      check($sformatf("v%0d_tank_dir", i), int'(tank_dir), tv[i].edir);
    end

    // Brick hit: tank (1,12) up, brick at (1,10)
    do_reset();
    poke(201, 2'd2);
    do_tick(8'h1A, lat);
    check("brk_tank_y", int'(tank_y), 12);
    do_tick(8'h14, lat);
    check("brk_spawn_live", int'(bul_live), 1);
    check("brk_spawn_x", int'(bul_x[0]), 1);
    check("brk_spawn_y", int'(bul_y[0]), 12);
    do_tick(8'h00, lat);
    check("brk_move_live", int'(bul_live), 1);
    check("brk_move_y", int'(bul_y[0]), 11);
    check("brk_move_raddr", rd_log[3], 221);
    w0 = we_cnt;
    do_tick(8'h00, lat);
    check("brk_raddr", rd_log[3], 201);
    check("brk_we_count", we_cnt - w0, 1);
    check("brk_waddr", last_waddr, 201);
    check("brk_wdata", last_wdata, 0);
    check("brk_live", int'(bul_live), 0);
    check("brk_mem", int'(mem[201]), 0);

    // Reset during B_CHK of a brick hit
    do_reset();
    poke(201, 2'd2);
    do_tick(8'h1A, lat);
    do_tick(8'h14, lat);
    do_tick(8'h00, lat);
    keycode = 8'h00;
    tick    = 1'b1;
    step(1);
    tick    = 1'b0;
    step(3);
    check("mid_we_before", int'(mif.map_we), 1);
    check("mid_waddr_before", int'(mif.map_waddr), 201);
    w0    = we_cnt;
    Reset = 1'b1;
    #1;
    check("mid_we", int'(mif.map_we), 0);
    check("mid_waddr", int'(mif.map_waddr), 0);
    check("mid_raddr", int'(mif.map_raddr), 0);
    check("mid_busy", int'(busy), 0);
    check("mid_done", int'(done), 0);
    check("mid_tank_x", int'(tank_x), 1);
    check("mid_tank_y", int'(tank_y), 13);
    check("mid_tank_dir", int'(tank_dir), 0);
    check("mid_bul_live", int'(bul_live), 0);
    check("mid_bul_xy", int'({bul_x, bul_y}), 0);
    step(2);
    Reset = 1'b0;
    step(1);
    check("mid_no_write", we_cnt - w0, 0);
    check("mid_mem", int'(mem[201]), 2);
    do_tick(8'h14, lat);
    check("mid_cd_cleared", int'(bul_live), 1);
    check("mid_spawn_y", int'(bul_y[0]), 13);

    // Fire held: tank at (1,13) facing right, open row
    do_reset();
    do_tick(8'h04, lat);
    check("fire_setup_x0", int'(tank_x), 0);
    do_tick(8'h07, lat);
    check("fire_setup_x1", int'(tank_x), 1);
    check("fire_setup_dir", int'(tank_dir), 3);
    for (int k = 1; k <= 21; k++) begin
      do_tick(8'h14, lat);
      ex0 = (k <= 19) ? k : k - 19;
      check($sformatf("fire%0d_lat", k), lat, 8);
      check($sformatf("fire%0d_live", k), int'(bul_live), (k < 10) ? 1 : 3);
      check($sformatf("fire%0d_x0", k), int'(bul_x[0]), ex0);
      if (k >= 10) check($sformatf("fire%0d_x1", k), int'(bul_x[1]), k - 9);
      if (k == 19) check("fire19_raddr0", rd_log[3], 13*MAP_W + 19);
      if (k == 20) begin
        check("fire20_edge_noread", rd_log[3], 0);
        check("fire20_raddr1", rd_log[5], 13*MAP_W + 11);
      end
    end
    check("fire_y0", int'(bul_y[0]), 13);
    check("fire_y1", int'(bul_y[1]), 13);

    // Tick while busy is ignored
    d0      = done_cnt;
    keycode = 8'h04;
    tick    = 1'b1;
    step(1);
    tick    = 1'b0;
    step(2);
    check("busy_flag", int'(busy), 1);
    tick = 1'b1;
    step(1);
    tick    = 1'b0;
    keycode = 8'h00;
    step(20);
    check("busy_done_cnt", done_cnt - d0, 1);
    check("busy_tank_x", int'(tank_x), 0);
    check("busy_idle", int'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
